keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// 4x4 matrix keypad scanner. One column is driven low per slot, rows are
// sampled once per slot, and each frame yields the first single-row hit in
// scan order. Accepted key changes become press events on a single-entry
// valid/ready output; an event that finds the entry occupied is dropped and
// recorded in a sticky overflow flag.
//
// Build option: KEYPAD_DEBOUNCE_EN
//   defined   - a frame result must repeat DEBOUNCE_SCANS times before it is
//               accepted.
//   undefined - every frame result is accepted directly, and no debounce
//               counter exists.
//
// state  | meaning
// DRIVE0 | column C1 driven low (cols_o = 0111)
// DRIVE1 | column C2 driven low (cols_o = 1011)
// DRIVE2 | column C3 driven low (cols_o = 1101)
// DRIVE3 | column C4 driven low (cols_o = 1110), frame evaluated on last clock
module keypad_scan_ctrl #(
    parameter int CLKS_PER_COL   = 100000,
    parameter int SETTLE_CLKS    = 8,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] rows_i,
    output logic [3:0] cols_o,
    output logic       key_valid_o,
    input  logic       key_ready_i,
    output logic [1:0] key_row_o,
    output logic [1:0] key_col_o,
    output logic       key_held_o,
    output logic       overflow_o
);

    typedef enum logic [1:0] {
        DRIVE0 = 2'd0,
        DRIVE1 = 2'd1,
        DRIVE2 = 2'd2,
        DRIVE3 = 2'd3
    } state_t;

    localparam logic [19:0] SLOT_LAST = 20'(CLKS_PER_COL - 1);
    localparam logic [19:0] SAMPLE_AT = 20'(SETTLE_CLKS);

    // An out-of-range parameter set leaves this marker scope in the
    // elaborated hierarchy so it is easy to find in a netlist browser.
    if ((CLKS_PER_COL < 16) || (CLKS_PER_COL > 1048575) ||
        (SETTLE_CLKS < 1) || (SETTLE_CLKS > CLKS_PER_COL - 2) ||
        (DEBOUNCE_SCANS < 1) || (DEBOUNCE_SCANS > 15)) begin : g_param_range_error
    end

    // Keys are carried as {row, col}; a separate valid bit encodes NONE and
    // the key field is kept at zero whenever the valid bit is clear.
    state_t      state_q, state_d;
    logic [19:0] slot_cnt_q, slot_cnt_d;
    logic        frm_hit_q, frm_hit_d;
    logic [3:0]  frm_key_q, frm_key_d;
    logic        acc_vld_q, acc_vld_d;
    logic [3:0]  acc_key_q, acc_key_d;
    logic        kv_q, kv_d;
    logic [3:0]  out_key_q, out_key_d;
    logic        ovf_q, ovf_d;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);
    logic        cand_vld_q, cand_vld_d;
    logic [3:0]  cand_key_q, cand_key_d;
    logic [3:0]  db_cnt_q, db_cnt_d;
    logic        res_eq_cand;
`endif

    logic        slot_end;
    logic        sample_now;
    logic        frame_end;
    logic        row_hit;
    logic [1:0]  row_idx;
    logic        press_evt;

    assign slot_end   = (slot_cnt_q >= SLOT_LAST);
    assign sample_now = (slot_cnt_q == SAMPLE_AT);
    assign frame_end  = slot_end && (state_q == DRIVE3);

    // Scan state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= DRIVE0;
            slot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
        end
    end

    // Slot timing, column advance and column drive decode.
    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q + 20'd1;
        cols_o     = 4'b0111;
        if (slot_end) begin
            slot_cnt_d = '0;
            case (state_q)
                DRIVE0:  state_d = DRIVE1;
                DRIVE1:  state_d = DRIVE2;
                DRIVE2:  state_d = DRIVE3;
                default: state_d = DRIVE0;
            endcase
        end
        case (state_q)
            DRIVE0:  cols_o = 4'b0111;
            DRIVE1:  cols_o = 4'b1011;
            DRIVE2:  cols_o = 4'b1101;
            default: cols_o = 4'b1110;
        endcase
    end

    // Row decode: only a single low row is a hit, anything else is rejected
    // as an idle column or a ghosting pattern.
    always_comb begin
        row_hit = 1'b1;
        row_idx = 2'd0;
        case (rows_i)
            4'b0111: row_idx = 2'd0;
            4'b1011: row_idx = 2'd1;
            4'b1101: row_idx = 2'd2;
            4'b1110: row_idx = 2'd3;
            default: row_hit = 1'b0;
        endcase
    end

    // Frame accumulator: keep the first hit in scan order, clear at frame end.
    // The sample point never coincides with the last clock of a slot, so the
    // DRIVE3 sample is always registered before the frame is evaluated.
    always_comb begin
        frm_hit_d = frm_hit_q;
        frm_key_d = frm_key_q;
        if (frame_end) begin
            frm_hit_d = 1'b0;
            frm_key_d = '0;
        end else if (sample_now && row_hit && !frm_hit_q) begin
            frm_hit_d = 1'b1;
            frm_key_d = {row_idx, state_q};
        end
    end

    // Acceptance of the frame result and press-event detection.
    always_comb begin
        acc_vld_d = acc_vld_q;
        acc_key_d = acc_key_q;
`ifdef KEYPAD_DEBOUNCE_EN
        cand_vld_d  = cand_vld_q;
        cand_key_d  = cand_key_q;
        db_cnt_d    = db_cnt_q;
        res_eq_cand = (frm_hit_q == cand_vld_q) && (frm_key_q == cand_key_q);
        if (frame_end) begin
            if (res_eq_cand) begin
                if (db_cnt_q < DB_TARGET) begin
                    db_cnt_d = db_cnt_q + 4'd1;
                end
            end else begin
                cand_vld_d = frm_hit_q;
                cand_key_d = frm_key_q;
                db_cnt_d   = 4'd1;
            end
            if (db_cnt_d == DB_TARGET) begin
                acc_vld_d = cand_vld_d;
                acc_key_d = cand_key_d;
            end
        end
`else
        if (frame_end) begin
            acc_vld_d = frm_hit_q;
            acc_key_d = frm_key_q;
        end
`endif
        press_evt = frame_end && acc_vld_d &&
                    (!acc_vld_q || (acc_key_d != acc_key_q));
    end

    // Single-entry event output; events that find it occupied are dropped.
    always_comb begin
        kv_d      = kv_q;
        out_key_d = out_key_q;
        ovf_d     = ovf_q;
        if (press_evt) begin
            if (!kv_q || key_ready_i) begin
                kv_d      = 1'b1;
                out_key_d = acc_key_d;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (kv_q && key_ready_i) begin
            kv_d = 1'b0;
        end
    end

    // Datapath registers; reset also discards any partial frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frm_hit_q  <= 1'b0;
            frm_key_q  <= '0;
            acc_vld_q  <= 1'b0;
            acc_key_q  <= '0;
            kv_q       <= 1'b0;
            out_key_q  <= '0;
            ovf_q      <= 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
            cand_vld_q <= 1'b0;
            cand_key_q <= '0;
            db_cnt_q   <= '0;
`endif
        end else begin
            frm_hit_q  <= frm_hit_d;
            frm_key_q  <= frm_key_d;
            acc_vld_q  <= acc_vld_d;
            acc_key_q  <= acc_key_d;
            kv_q       <= kv_d;
            out_key_q  <= out_key_d;
            ovf_q      <= ovf_d;
`ifdef KEYPAD_DEBOUNCE_EN
            cand_vld_q <= cand_vld_d;
            cand_key_q <= cand_key_d;
            db_cnt_q   <= db_cnt_d;
`endif
        end
    end

    assign key_valid_o = kv_q;
    assign key_row_o   = out_key_q[3:2];
    assign key_col_o   = out_key_q[1:0];
    assign key_held_o  = acc_vld_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed testbench for keypad_scan_ctrl with a small 4x4 keypad model.
// Expected timing is written in clocks counted from the last reset edge;
// one frame is 4*C clocks and acceptance takes FR frames.
module tb_keypad_scan_ctrl;

    localparam int C  = 16;
    localparam int S  = 8;
    localparam int DB = 4;
    localparam int F  = 4 * C;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int FR = DB;
`else
    localparam int FR = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        key_valid;
    logic        key_ready;
    logic [1:0]  key_row;
    logic [1:0]  key_col;
    logic        key_held;
    logic        overflow;

    logic [15:0] keys;   // bit r*4+c = key at row r, column c pressed
    logic        ghost;  // force rows to a two-low pattern in every slot

    int checks = 0;
    int errors = 0;

    keypad_scan_ctrl #(
        .CLKS_PER_COL   (C),
        .SETTLE_CLKS    (S),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rows_i      (rows),
        .cols_o      (cols),
        .key_valid_o (key_valid),
        .key_ready_i (key_ready),
        .key_row_o   (key_row),
        .key_col_o   (key_col),
        .key_held_o  (key_held),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] col_drive(input int c);
        case (c)
            0:       return 4'b0111;
            1:       return 4'b1011;
            2:       return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    // Keypad model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        rows = 4'b1111;
        if (ghost) begin
            rows = 4'b1001;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (cols == col_drive(c)) begin
                    for (int r = 0; r < 4; r++) begin
                        if (keys[r*4+c]) rows[3-r] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        key_ready = 1'b1;
        keys      = '0;
        ghost     = 1'b0;

        // Reset values and column stepping.
        do_reset();
        chk("rst_cols",  cols,          4'b0111);
        chk("rst_valid", 4'(key_valid), 4'd0);
        chk("rst_row",   4'(key_row),   4'd0);
        chk("rst_col",   4'(key_col),   4'd0);
        chk("rst_held",  4'(key_held),  4'd0);
        chk("rst_ovf",   4'(overflow),  4'd0);
        tick(C - 1);
        chk("cols_c1_last", cols, 4'b0111);
        tick(1);
        chk("cols_c2", cols, 4'b1011);
        tick(C);
        chk("cols_c3", cols, 4'b1101);
        tick(C);
        chk("cols_c4", cols, 4'b1110);
        tick(C);
        chk("cols_wrap", cols, 4'b0111);
        chk("idle_valid", 4'(key_valid), 4'd0);

        // Single key row2/col1, consumer always ready.
        do_reset();
        keys[2*4+1] = 1'b1;
        tick(FR*F - 1);
        chk("a_valid_early", 4'(key_valid), 4'd0);
        tick(1);
        chk("a_valid", 4'(key_valid), 4'd1);
        chk("a_row",   4'(key_row),   4'd2);
        chk("a_col",   4'(key_col),   4'd1);
        chk("a_held",  4'(key_held),  4'd1);
        tick(1);
        chk("a_consumed", 4'(key_valid), 4'd0);
        keys = '0;
        tick(FR*F - 2);
        chk("a_held_before_release", 4'(key_held),  4'd1);
        chk("a_no_repeat",           4'(key_valid), 4'd0);
        tick(1);
        chk("a_released",       4'(key_held),  4'd0);
        chk("a_release_no_evt", 4'(key_valid), 4'd0);

        // Two low rows in every slot must never register.
        do_reset();
        ghost = 1'b1;
        tick((FR + 1) * F);
        chk("ghost_valid", 4'(key_valid), 4'd0);
        chk("ghost_held",  4'(key_held),  4'd0);
        ghost = 1'b0;

        // Two keys in different columns: lowest column wins.
        do_reset();
        keys[1*4+2] = 1'b1;
        keys[3*4+0] = 1'b1;
        tick(FR*F);
        chk("order_valid", 4'(key_valid), 4'd1);
        chk("order_row",   4'(key_row),   4'd3);
        chk("order_col",   4'(key_col),   4'd0);
        keys = '0;

        // Consumer stalled: second press is dropped and overflow latches.
        do_reset();
        key_ready = 1'b0;
        keys[0]   = 1'b1;
        tick(FR*F);
        chk("ovf_first_valid", 4'(key_valid), 4'd1);
        chk("ovf_first_row",   4'(key_row),   4'd0);
        chk("ovf_first_col",   4'(key_col),   4'd0);
        keys = '0;
        tick(F);
        keys[3*4+3] = 1'b1;
        tick(FR*F - 1);
        chk("ovf_not_yet", 4'(overflow),  4'd0);
        tick(1);
        chk("ovf_set",      4'(overflow),  4'd1);
        chk("ovf_valid",    4'(key_valid), 4'd1);
        chk("ovf_row_kept", 4'(key_row),   4'd0);
        chk("ovf_col_kept", 4'(key_col),   4'd0);
        tick(2*C + 8);
        chk("ovf_sticky",     4'(overflow),  4'd1);
        chk("ovf_hold_valid", 4'(key_valid), 4'd1);
        chk("ovf_held_33",    4'(key_held),  4'd1);

        // Reset mid-DRIVE2 with an event pending and ready high.
        chk("mid_drive2", cols, 4'b1101);
        key_ready = 1'b1;
        rst       = 1'b1;
        tick(1);
        chk("mrst_valid", 4'(key_valid), 4'd0);
        chk("mrst_ovf",   4'(overflow),  4'd0);
        chk("mrst_cols",  cols,          4'b0111);
        chk("mrst_held",  4'(key_held),  4'd0);
        rst = 1'b0;
        tick(C - 1);
        chk("resume_c1", cols, 4'b0111);
        tick(1);
        chk("resume_c2", cols, 4'b1011);
        tick(FR*F - C - 1);
        chk("resume_early", 4'(key_valid), 4'd0);
        tick(1);
        chk("resume_valid", 4'(key_valid), 4'd1);
        chk("resume_row",   4'(key_row),   4'd3);
        chk("resume_col",   4'(key_col),   4'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
